// File: rtl/glyph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_pkg
//  Description : Shared types and constants for the glyph renderer: the
//                per-slot configuration record and the special glyph ids.
//  Revision    : 1.0 - initial release
// ============================================================================
package glyph_pkg;

    // Every glyph bitmap is eight rows tall
    localparam int GLYPH_ROWS = 8;

    // Glyph ids with dedicated bitmaps; 0-7 are digits, anything above 9 is a solid block
    localparam logic [3:0] GLYPH_CAT = 4'd8;
    localparam logic [3:0] GLYPH_WIN = 4'd9;

    // Storage widths inside a slot record; coordinates are zero-extended into these
    localparam int GLYPH_XY_W = 16;
    localparam int GLYPH_SC_W = 4;

    typedef struct packed {
        logic                  en;
        logic [3:0]            id;
        logic [GLYPH_XY_W-1:0] x;
        logic [GLYPH_XY_W-1:0] y;
        logic [GLYPH_SC_W-1:0] scale;
        logic                  blink;
    } slot_cfg_t;

endpackage
`default_nettype wire

// File: rtl/glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_rom
//  Description : Combinational bitmap store for digits 0-7, the cat sprite,
//                the WIN banner and a solid block. Bit GLYPH_W-1 is the
//                leftmost column; 8-wide glyphs sit in the leftmost 8 columns.
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int GLYPH_W = 16
) (
    input  logic [3:0]         id,
    input  logic [2:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    // Digit bitmaps, row 0 in the most significant byte
    localparam logic [63:0] c_digits [0:7] = '{
        64'h3C666E7666663C00,
        64'h1838181818187E00,
        64'h3C66060C30607E00,
        64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00,
        64'h7E607C0606663C00,
        64'h3C607C6666663C00,
        64'h7E060C1830303000
    };
    localparam logic [127:0] c_cat = 128'h0810_1C38_1FF8_3BDC_3FFC_1E78_0FF0_0660;
    localparam logic [127:0] c_win = 128'h8BA2_8932_A92A_A926_D922_8BA2_0000_0000;

    logic [2:0]  w_inv;
    logic [15:0] w_row16;

    // Select one 16-column row of the requested glyph
    always_comb begin
        w_inv   = 3'd7 - row;
        w_row16 = '0;
        case (id)
            GLYPH_CAT: w_row16 = c_cat[{w_inv, 4'b0000} +: 16];
            GLYPH_WIN: w_row16 = c_win[{w_inv, 4'b0000} +: 16];
            default: begin
                if (id[3] == 1'b0) begin
                    w_row16 = {c_digits[id[2:0]][{w_inv, 3'b000} +: 8], 8'h00};
                end else begin
                    w_row16 = 16'hFFFF;
                end
            end
        endcase
    end

    if (GLYPH_W == 16) begin : g_w16
        assign bits = w_row16;
    end else begin : g_w8
        assign bits = w_row16[15:8];
    end

endmodule
`default_nettype wire

// File: rtl/glyph_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_renderer
//  Description : Multi-slot, two-stage pipelined 8-row glyph renderer.
//                Slot configuration is double-buffered and swapped on
//                frame_start. Optional blinking is built when the macro
//                GLYPH_RENDERER_BLINK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_renderer
    import glyph_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int GLYPH_W        = 16,
    parameter int COORD_W        = 10,
    parameter int MAX_SCALE_LOG2 = 3,
    parameter int BLINK_LOG2     = 4,
    localparam int SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int SCALE_W       = (MAX_SCALE_LOG2 > 0) ? $clog2(MAX_SCALE_LOG2 + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [SLOT_W-1:0]  cfg_slot,
    input  logic               cfg_en,
    input  logic [3:0]         cfg_id,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic               cfg_blink,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               out_valid,
    output logic               out_on,
    output logic [SLOT_W-1:0]  out_slot
);

    localparam int c_col_w = $clog2(GLYPH_W);
    localparam int c_cmp_w = GLYPH_XY_W + 4;

    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || (GLYPH_W != 8 && GLYPH_W != 16) ||
        COORD_W > GLYPH_XY_W || BLINK_LOG2 < 0 || MAX_SCALE_LOG2 < 0) begin : g_param_check
        $error("glyph_renderer: unsupported parameter combination");
    end

    slot_cfg_t              r_pend [NUM_SLOTS];
    slot_cfg_t              r_act  [NUM_SLOTS];
    slot_cfg_t              w_new;
    logic                   w_blink_phase;
    logic                   r_s1_valid;
    logic [NUM_SLOTS-1:0]   w_lit;
    logic                   w_any;
    logic [SLOT_W-1:0]      w_win;

    // Incoming configuration record, coordinates widened to storage width
    always_comb begin
        w_new       = '0;
        w_new.en    = cfg_en;
        w_new.id    = cfg_id;
        w_new.x     = GLYPH_XY_W'(cfg_x);
        w_new.y     = GLYPH_XY_W'(cfg_y);
        w_new.scale = GLYPH_SC_W'(cfg_scale);
        w_new.blink = cfg_blink;
    end

    // Pending bank takes writes; active bank copies pending (plus a same-cycle write) at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_pend[i] <= '0;
                r_act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_we && cfg_slot == SLOT_W'(i)) begin
                    r_pend[i] <= w_new;
                end
                if (frame_start) begin
                    r_act[i] <= (cfg_we && cfg_slot == SLOT_W'(i)) ? w_new : r_pend[i];
                end
            end
        end
    end

`ifdef GLYPH_RENDERER_BLINK_EN
    logic [BLINK_LOG2:0] r_frame_cnt;

    // Frame counter whose top bit is the blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_blink_phase = r_frame_cnt[BLINK_LOG2];
`else
    assign w_blink_phase = 1'b0;
`endif

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_cfg_t             w_cfg;
        logic [GLYPH_SC_W-1:0] w_sc;
        logic [GLYPH_XY_W-1:0] w_px, w_py, w_dx, w_dy, w_colw, w_roww;
        logic [c_cmp_w-1:0]    w_xlim, w_ylim;
        logic                  w_en, w_hit;
        logic                  r_hit;
        logic [c_col_w-1:0]    r_col;
        logic [2:0]            r_row;
        logic [3:0]            r_id;
        logic [GLYPH_W-1:0]    w_bits;
        logic [c_col_w-1:0]    w_bit_idx;

        // Stage 1 geometry: bounding-box test and glyph cell coordinates
        always_comb begin
            w_cfg  = r_act[i];
            w_sc   = (w_cfg.scale > GLYPH_SC_W'(MAX_SCALE_LOG2)) ?
                     GLYPH_SC_W'(MAX_SCALE_LOG2) : w_cfg.scale;
            w_en   = w_cfg.en & ~(w_cfg.blink & w_blink_phase);
            w_px   = GLYPH_XY_W'(pix_x);
            w_py   = GLYPH_XY_W'(pix_y);
            w_dx   = w_px - w_cfg.x;
            w_dy   = w_py - w_cfg.y;
            w_xlim = c_cmp_w'(GLYPH_W) << w_sc;
            w_ylim = c_cmp_w'(GLYPH_ROWS) << w_sc;
            w_colw = w_dx >> w_sc;
            w_roww = w_dy >> w_sc;
            // The upper-bit checks are implied by the limits; they keep the col/row slices exact
            w_hit  = pix_valid & w_en &
                     (w_px >= w_cfg.x) & (w_py >= w_cfg.y) &
                     (c_cmp_w'(w_dx) < w_xlim) & (c_cmp_w'(w_dy) < w_ylim) &
                     (w_colw[GLYPH_XY_W-1:c_col_w] == '0) & (w_roww[GLYPH_XY_W-1:3] == '0);
        end

        // Stage 1 register: hit flag, cell coordinates and the glyph id used for lookup
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hit <= 1'b0;
                r_col <= '0;
                r_row <= '0;
                r_id  <= '0;
            end else begin
                r_hit <= w_hit;
                r_col <= w_colw[c_col_w-1:0];
                r_row <= w_roww[2:0];
                r_id  <= w_cfg.id;
            end
        end

        glyph_rom #(
            .GLYPH_W (GLYPH_W)
        ) u_rom (
            .id   (r_id),
            .row  (r_row),
            .bits (w_bits)
        );

        assign w_bit_idx = c_col_w'(GLYPH_W - 1) - r_col;
        assign w_lit[i]  = r_hit & w_bits[w_bit_idx];
    end

    // Lowest-index lit slot wins
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_lit[i]) begin
                w_any = 1'b1;
                w_win = SLOT_W'(i);
            end
        end
    end

    // Pipeline valid and stage 2 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_on     <= 1'b0;
            out_slot   <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            out_valid  <= r_s1_valid;
            out_on     <= w_any;
            out_slot   <= w_any ? w_win : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glyph_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glyph_renderer
//  Description : Directed self-checking bench for glyph_renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_slot = '0;
    logic       cfg_en = 1'b0;
    logic [3:0] cfg_id = '0;
    logic [9:0] cfg_x = '0;
    logic [9:0] cfg_y = '0;
    logic [1:0] cfg_scale = '0;
    logic       cfg_blink = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       out_valid;
    logic       out_on;
    logic [1:0] out_slot;

    int n_vec = 0;
    int n_err = 0;

    glyph_renderer #(
        .NUM_SLOTS      (4),
        .GLYPH_W        (16),
        .COORD_W        (10),
        .MAX_SCALE_LOG2 (3),
        .BLINK_LOG2     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_slot    (cfg_slot),
        .cfg_en      (cfg_en),
        .cfg_id      (cfg_id),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_scale   (cfg_scale),
        .cfg_blink   (cfg_blink),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .out_valid   (out_valid),
        .out_on      (out_on),
        .out_slot    (out_slot)
    );

    always #5 clk = ~clk;

    // Write one slot's pending entry, optionally with frame_start in the same cycle
    task automatic write_cfg(input int slot, input logic en, input int id, input int x,
                             input int y, input int sc, input logic blink, input logic fs);
        @(negedge clk);
        cfg_we = 1'b1; cfg_slot = 2'(slot); cfg_en = en; cfg_id = 4'(id);
        cfg_x = 10'(x); cfg_y = 10'(y); cfg_scale = 2'(sc); cfg_blink = blink;
        frame_start = fs;
        @(negedge clk);
        cfg_we = 1'b0; frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Present one pixel and return the outputs two cycles later
    task automatic send_pixel(input int x, input int y, output logic v, output logic on,
                              output logic [1:0] s);
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        v = out_valid; on = out_on; s = out_slot;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_on !== 1'b0) begin n_err++; $display("FAIL reset_on got %b want 0", out_on); end
        n_vec++; if (out_slot !== 2'd0) begin n_err++; $display("FAIL reset_slot got %0d want 0", out_slot); end
        rst_n = 1'b1;
    endtask

    task automatic test_pipeline();
        logic [11:0] pat;
        pat = 12'b0101_1100_1011;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                n_vec++;
                if (out_valid !== pat[k-2] || out_on !== 1'b0) begin
                    n_err++;
                    $display("FAIL sweep[%0d] got valid=%b on=%b want valid=%b on=0", k, out_valid, out_on, pat[k-2]);
                end
            end
            pix_valid = (k < 12) ? pat[k] : 1'b0;
            pix_x = 10'(k * 37); pix_y = 10'(k * 11);
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_scale0();
        int xs [6] = '{103, 100, 103, 104, 99, 101};
        int ys [6] = '{50, 50, 58, 50, 50, 56};
        logic exp_on [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic v, on; logic [1:0] s;
        write_cfg(0, 1'b1, 1, 100, 50, 0, 1'b0, 1'b0);
        pulse_frame();
        for (int k = 0; k < 6; k++) begin
            send_pixel(xs[k], ys[k], v, on, s);
            n_vec++;
            if (v !== 1'b1 || on !== exp_on[k] || s !== 2'd0) begin
                n_err++;
                $display("FAIL scale0 (%0d,%0d) got v=%b on=%b slot=%0d want v=1 on=%b slot=0",
                         xs[k], ys[k], v, on, s, exp_on[k]);
            end
        end
    endtask

    task automatic test_scale2();
        int xs [7] = '{112, 100, 111, 147, 115, 112, 104};
        int ys [7] = '{50, 50, 50, 81, 53, 82, 74};
        logic exp_on [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic v, on; logic [1:0] s;
        write_cfg(0, 1'b1, 1, 100, 50, 2, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            send_pixel(xs[k], ys[k], v, on, s);
            n_vec++;
            if (on !== exp_on[k]) begin
                n_err++;
                $display("FAIL scale2 (%0d,%0d) got on=%b want %b", xs[k], ys[k], on, exp_on[k]);
            end
        end
    endtask

    task automatic test_priority();
        logic v, on; logic [1:0] s;
        write_cfg(0, 1'b1, 15, 10, 10, 0, 1'b0, 1'b0);
        write_cfg(2, 1'b1, 15, 10, 10, 0, 1'b0, 1'b0);
        pulse_frame();
        send_pixel(12, 12, v, on, s);
        n_vec++; if (on !== 1'b1 || s !== 2'd0) begin n_err++; $display("FAIL prio_both got on=%b slot=%0d want on=1 slot=0", on, s); end
        write_cfg(0, 1'b0, 15, 10, 10, 0, 1'b0, 1'b1);
        send_pixel(12, 12, v, on, s);
        n_vec++; if (on !== 1'b1 || s !== 2'd2) begin n_err++; $display("FAIL prio_slot2 got on=%b slot=%0d want on=1 slot=2", on, s); end
        send_pixel(25, 12, v, on, s);
        n_vec++; if (on !== 1'b1 || s !== 2'd2) begin n_err++; $display("FAIL prio_right_edge got on=%b slot=%0d want on=1 slot=2", on, s); end
        send_pixel(26, 12, v, on, s);
        n_vec++; if (on !== 1'b0 || s !== 2'd0) begin n_err++; $display("FAIL prio_past_edge got on=%b slot=%0d want on=0 slot=0", on, s); end
    endtask

    task automatic test_double_buffer();
        logic v, on; logic [1:0] s;
        write_cfg(2, 1'b0, 15, 10, 10, 0, 1'b0, 1'b0);
        write_cfg(0, 1'b1, 15, 10, 10, 0, 1'b0, 1'b1);
        send_pixel(12, 12, v, on, s);
        n_vec++; if (on !== 1'b1 || s !== 2'd0) begin n_err++; $display("FAIL dbuf_base got on=%b slot=%0d want on=1 slot=0", on, s); end
        write_cfg(0, 1'b1, 15, 200, 10, 0, 1'b0, 1'b0);
        send_pixel(12, 12, v, on, s);
        n_vec++; if (on !== 1'b1) begin n_err++; $display("FAIL dbuf_old_kept got on=%b want 1", on); end
        send_pixel(202, 12, v, on, s);
        n_vec++; if (on !== 1'b0) begin n_err++; $display("FAIL dbuf_new_hidden got on=%b want 0", on); end
        write_cfg(0, 1'b1, 15, 200, 10, 0, 1'b0, 1'b1);
        send_pixel(202, 12, v, on, s);
        n_vec++; if (on !== 1'b1) begin n_err++; $display("FAIL dbuf_same_cycle got on=%b want 1", on); end
        send_pixel(12, 12, v, on, s);
        n_vec++; if (on !== 1'b0) begin n_err++; $display("FAIL dbuf_old_gone got on=%b want 0", on); end
    endtask

    task automatic test_back_to_back();
        int   xs [4] = '{199, 200, 201, 216};
        logic ex [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_on !== ex[k-2]) begin
                    n_err++;
                    $display("FAIL b2b x=%0d got v=%b on=%b want v=1 on=%b", xs[k-2], out_valid, out_on, ex[k-2]);
                end
            end
            pix_valid = (k < 4);
            pix_x = (k < 4) ? 10'(xs[k]) : 10'd0;
            pix_y = 10'd12;
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_frame_in_flight();
        write_cfg(0, 1'b1, 15, 10, 10, 0, 1'b0, 1'b0);
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 10'd202; pix_y = 10'd12; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; pix_x = 10'd202;
        @(negedge clk);
        n_vec++; if (out_on !== 1'b1) begin n_err++; $display("FAIL flight_old_bank got on=%b want 1", out_on); end
        pix_x = 10'd12;
        @(negedge clk);
        n_vec++; if (out_on !== 1'b0) begin n_err++; $display("FAIL flight_new_bank got on=%b want 0", out_on); end
        pix_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_on !== 1'b1) begin n_err++; $display("FAIL flight_new_hit got on=%b want 1", out_on); end
    endtask

    task automatic test_mid_reset();
        logic v, on; logic [1:0] s;
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 10'd12; pix_y = 10'd12;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (out_on !== 1'b1) begin n_err++; $display("FAIL pre_reset_on got %b want 1", out_on); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_on !== 1'b0 || out_valid !== 1'b0 || out_slot !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset got v=%b on=%b slot=%0d want 0/0/0", out_valid, out_on, out_slot);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b1;
        send_pixel(12, 12, v, on, s);
        n_vec++; if (v !== 1'b1 || on !== 1'b0) begin n_err++; $display("FAIL post_reset_cleared got v=%b on=%b want v=1 on=0", v, on); end
    endtask

`ifdef GLYPH_RENDERER_BLINK_EN
    task automatic test_blink();
        logic v, on; logic [1:0] s;
        logic ex [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        write_cfg(0, 1'b1, 15, 10, 10, 0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) pulse_frame();
            send_pixel(12, 12, v, on, s);
            n_vec++;
            if (on !== ex[k]) begin n_err++; $display("FAIL blink_frame%0d got on=%b want %b", k, on, ex[k]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pipeline();
        test_scale0();
        test_scale2();
        test_priority();
        test_double_buffer();
        test_back_to_back();
        test_frame_in_flight();
        test_mid_reset();
`ifdef GLYPH_RENDERER_BLINK_EN
        test_blink();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
